// File: rtl/linear_layer_ctrl.sv
// Sequencer for one linear_layer: streams weights then biases from a synchronous parameter
// ROM into the layer, issues one input vector and returns the result or a timeout error.
module linear_layer_ctrl #(
  parameter int IN_DIM     = 4,
  parameter int OUT_DIM    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 64,
  localparam int NW = IN_DIM * OUT_DIM,
  localparam int N  = NW + OUT_DIM,
  localparam int AW = (N > 1) ? $clog2(N) : 1,
  localparam int RW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1,
  localparam int CW = (IN_DIM > 1) ? $clog2(IN_DIM) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                reload,
  input  logic [IN_DIM*DATA_WIDTH-1:0]        x_vec,
  output logic                                busy,
  output logic                                done,
  output logic                                error,
  output logic                                weights_valid,
  output logic [OUT_DIM*DATA_WIDTH-1:0]       y_vec,
  output logic [AW-1:0]                       pmem_addr,
  input  logic signed [DATA_WIDTH-1:0]        pmem_data,
  output logic                                load_weight,
  output logic [RW-1:0]                       w_row,
  output logic [CW-1:0]                       w_col,
  output logic signed [DATA_WIDTH-1:0]        w_data,
  output logic                                load_bias,
  output logic [RW-1:0]                       b_idx,
  output logic signed [DATA_WIDTH-1:0]        b_data,
  output logic                                ll_valid_in,
  output logic [IN_DIM*DATA_WIDTH-1:0]        ll_x_in,
  input  logic                                ll_valid_out,
  input  logic [OUT_DIM*DATA_WIDTH-1:0]       ll_y_out
);

  // The address counter must be able to hold N for the final drain cycle of the load phase.
  localparam int KW = $clog2(N + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [KW-1:0] K_N    = KW'(N);
  localparam logic [KW-1:0] K_NW   = KW'(NW);
  localparam logic [CW-1:0] C_LAST = CW'(IN_DIM - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ISSUE = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [KW-1:0] k_p0;
  logic [RW-1:0] row_p0;
  logic [CW-1:0] col_p0;
  logic [RW-1:0] bidx_p0;

  logic          vld_w_p1;
  logic          vld_b_p1;
  logic [RW-1:0] w_row_p1;
  logic [CW-1:0] w_col_p1;
  logic [RW-1:0] b_idx_p1;

  logic [TW-1:0] wait_cnt;
  logic          wv_q;
  logic          done_q;
  logic          error_q;
  logic [IN_DIM*DATA_WIDTH-1:0]  x_cap;
  logic [OUT_DIM*DATA_WIDTH-1:0] y_q;

  logic need_load;
  logic load_last;
  logic wait_hit;

  assign need_load = reload || !wv_q;
  assign load_last = (k_p0 == K_N);
  assign wait_hit  = (wait_cnt == T_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = need_load ? S_LOAD : S_ISSUE;
      S_LOAD:  if (load_last) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (ll_valid_out || wait_hit) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != S_IDLE);
    ll_valid_in = (state == S_ISSUE);
    pmem_addr   = '0;
    if (state == S_LOAD && k_p0 < K_N) pmem_addr = k_p0[AW-1:0];
  end

  // Stage p0: address and row/col/bias counters; stage p1: strobe registered against ROM data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_p0     <= '0;
      row_p0   <= '0;
      col_p0   <= '0;
      bidx_p0  <= '0;
      vld_w_p1 <= 1'b0;
      vld_b_p1 <= 1'b0;
      w_row_p1 <= '0;
      w_col_p1 <= '0;
      b_idx_p1 <= '0;
      wait_cnt <= '0;
      wv_q     <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      x_cap    <= '0;
      y_q      <= '0;
    end else begin
      vld_w_p1 <= 1'b0;
      vld_b_p1 <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            x_cap <= x_vec;
            if (need_load) begin
              wv_q    <= 1'b0;
              k_p0    <= '0;
              row_p0  <= '0;
              col_p0  <= '0;
              bidx_p0 <= '0;
            end
          end
        end
        S_LOAD: begin
          if (!load_last) begin
            k_p0 <= k_p0 + 1'b1;
            if (k_p0 < K_NW) begin
              vld_w_p1 <= 1'b1;
              w_row_p1 <= row_p0;
              w_col_p1 <= col_p0;
              if (col_p0 == C_LAST) begin
                col_p0 <= '0;
                row_p0 <= row_p0 + 1'b1;
              end else begin
                col_p0 <= col_p0 + 1'b1;
              end
            end else begin
              vld_b_p1 <= 1'b1;
              b_idx_p1 <= bidx_p0;
              bidx_p0  <= bidx_p0 + 1'b1;
            end
          end else begin
            wv_q <= 1'b1;
          end
        end
        S_ISSUE: wait_cnt <= '0;
        S_WAIT: begin
          // A result arriving on the timeout cycle still counts as success.
          if (ll_valid_out) begin
            y_q    <= ll_y_out;
            done_q <= 1'b1;
          end else if (wait_hit) begin
            error_q <= 1'b1;
            wv_q    <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign load_weight   = vld_w_p1;
  assign w_row         = w_row_p1;
  assign w_col         = w_col_p1;
  assign w_data        = vld_w_p1 ? pmem_data : '0;
  assign load_bias     = vld_b_p1;
  assign b_idx         = b_idx_p1;
  assign b_data        = vld_b_p1 ? pmem_data : '0;
  assign weights_valid = wv_q;
  assign done          = done_q;
  assign error         = error_q;
  assign y_vec         = y_q;
  assign ll_x_in       = x_cap;

endmodule

// File: tb/tb_linear_layer_ctrl.sv
// Bench for linear_layer_ctrl: synchronous ROM, behavioural Q8.8 linear layer, strobe monitor,
// and directed plus randomized inference runs checked against a reference computed from the ROM.
module tb_linear_layer_ctrl;
  localparam int IN_DIM  = 4;
  localparam int OUT_DIM = 4;
  localparam int DW      = 16;
  localparam int TIMEOUT = 64;
  localparam int NW      = IN_DIM * OUT_DIM;
  localparam int N       = NW + OUT_DIM;
  localparam int AW      = 5;
  localparam int RW      = 2;
  localparam int CW      = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, reload;
  logic [IN_DIM*DW-1:0]  x_vec, ll_x_in;
  logic [OUT_DIM*DW-1:0] y_vec, ll_y_out;
  logic busy, done, error, weights_valid;
  logic [AW-1:0] pmem_addr;
  logic signed [DW-1:0] pmem_data, w_data, b_data;
  logic load_weight, load_bias, ll_valid_in, ll_valid_out;
  logic [RW-1:0] w_row, b_idx;
  logic [CW-1:0] w_col;

  linear_layer_ctrl #(.IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .reload(reload), .x_vec(x_vec),
    .busy(busy), .done(done), .error(error), .weights_valid(weights_valid), .y_vec(y_vec),
    .pmem_addr(pmem_addr), .pmem_data(pmem_data),
    .load_weight(load_weight), .w_row(w_row), .w_col(w_col), .w_data(w_data),
    .load_bias(load_bias), .b_idx(b_idx), .b_data(b_data),
    .ll_valid_in(ll_valid_in), .ll_x_in(ll_x_in), .ll_valid_out(ll_valid_out), .ll_y_out(ll_y_out)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Parameter ROM, one cycle read latency
  logic [DW-1:0] rom [N];
  always @(posedge clk) pmem_data <= rom[pmem_addr];

  // Behavioural linear layer: Q8.8 matrix-vector product plus bias after lay_lat cycles
  logic signed [DW-1:0] wm [OUT_DIM][IN_DIM];
  logic signed [DW-1:0] bm [OUT_DIM];
  logic [IN_DIM*DW-1:0]  lx = '0;
  logic [OUT_DIM*DW-1:0] lay_y = '0;
  logic lay_vld = 1'b0;
  int   lcnt = 0;
  int   lay_lat;
  bit   lay_respond;
  logic inj_vld;
  logic [OUT_DIM*DW-1:0] inj_y;

  function automatic logic [OUT_DIM*DW-1:0] layer_fn();
    logic [OUT_DIM*DW-1:0] y;
    int acc;
    for (int i = 0; i < OUT_DIM; i++) begin
      acc = 0;
      for (int j = 0; j < IN_DIM; j++) acc += int'(wm[i][j]) * int'($signed(lx[j*DW +: DW]));
      y[i*DW +: DW] = 16'((acc >>> 8) + int'(bm[i]));
    end
    return y;
  endfunction

  always @(posedge clk) begin
    lay_vld <= 1'b0;
    if (load_weight === 1'b1) wm[w_row][w_col] <= w_data;
    if (load_bias === 1'b1)   bm[b_idx] <= b_data;
    if (rst_n !== 1'b1) begin
      lcnt <= 0;
    end else if (ll_valid_in === 1'b1 && lay_respond) begin
      lx   <= ll_x_in;
      lcnt <= lay_lat;
    end else if (lcnt > 0) begin
      lcnt <= lcnt - 1;
      if (lcnt == 1) begin
        lay_vld <= 1'b1;
        lay_y   <= layer_fn();
      end
    end
  end

  assign ll_valid_out = lay_vld | inj_vld;
  assign ll_y_out     = inj_vld ? inj_y : lay_y;

  // Strobe / event monitor, sampling on the falling edge
  logic [39:0] slog[$];
  int slog_cyc[$];
  int n_vin = 0, vin_cyc = 0, vout_cyc = 0, n_done = 0, done_cyc = 0, n_errp = 0, err_cyc = 0;
  logic viol_two = 1'b0, viol_both = 1'b0;

  always @(negedge clk) begin
    if (load_weight === 1'b1) begin
      slog.push_back({8'd1, 6'd0, w_row, 6'd0, w_col, w_data});
      slog_cyc.push_back(cyc);
    end
    if (load_bias === 1'b1) begin
      slog.push_back({8'd2, 6'd0, b_idx, 8'd0, b_data});
      slog_cyc.push_back(cyc);
    end
    if (load_weight === 1'b1 && load_bias === 1'b1) viol_two <= 1'b1;
    if (done === 1'b1 && error === 1'b1) viol_both <= 1'b1;
    if (ll_valid_in === 1'b1) begin n_vin <= n_vin + 1; vin_cyc <= cyc; end
    if (ll_valid_out === 1'b1) vout_cyc <= cyc;
    if (done === 1'b1) begin n_done <= n_done + 1; done_cyc <= cyc; end
    if (error === 1'b1) begin n_errp <= n_errp + 1; err_cyc <= cyc; end
  end

  int n_vec = 0;
  int n_miss = 0;
  int acc_c, log_b, vin_b, done_b, err_b;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Reference result straight from the ROM image and the caller's vector
  function automatic logic [OUT_DIM*DW-1:0] ref_y(input logic [IN_DIM*DW-1:0] x);
    logic [OUT_DIM*DW-1:0] y;
    int acc;
    for (int i = 0; i < OUT_DIM; i++) begin
      acc = 0;
      for (int j = 0; j < IN_DIM; j++)
        acc += int'($signed(rom[i*IN_DIM+j])) * int'($signed(x[j*DW +: DW]));
      y[i*DW +: DW] = 16'((acc >>> 8) + int'($signed(rom[NW+i])));
    end
    return y;
  endfunction

  task automatic rand_rom();
    for (int m = 0; m < N; m++) rom[m] = 16'(int'($urandom_range(0, 1023)) - 512);
  endtask

  function automatic logic [IN_DIM*DW-1:0] rand_x();
    logic [IN_DIM*DW-1:0] x;
    for (int j = 0; j < IN_DIM; j++) x[j*DW +: DW] = 16'(int'($urandom_range(0, 4095)) - 2048);
    return x;
  endfunction

  // Accept happens on the edge after cycle acc_c; the bench then stands in cycle acc_c+1.
  task automatic txn(input bit r, input logic [IN_DIM*DW-1:0] x);
    log_b  = slog.size();
    vin_b  = n_vin;
    done_b = n_done;
    err_b  = n_errp;
    start  = 1'b1;
    reload = r;
    x_vec  = x;
    acc_c  = cyc;
    step();
    start  = 1'b0;
    reload = 1'b0;
    x_vec  = ~x;
  endtask

  task automatic wait_end(input string tag);
    int i = 0;
    while (!(done === 1'b1 || error === 1'b1) && i < 200) begin
      step();
      i++;
    end
    chk({tag, "_finished"}, (done === 1'b1 || error === 1'b1), 1'b1);
  endtask

  task automatic chk_load(input string tag);
    logic [39:0] e;
    chk({tag, "_strobes"}, slog.size() - log_b, N);
    for (int m = 0; m < N; m++) begin
      if (m < NW) e = {8'd1, 8'(m / IN_DIM), 8'(m % IN_DIM), rom[m]};
      else        e = {8'd2, 8'(m - NW), 8'd0, rom[m]};
      chk($sformatf("%s_entry%0d", tag, m), slog[log_b+m], e);
      chk($sformatf("%s_cyc%0d", tag, m), slog_cyc[log_b+m], acc_c + 2 + m);
    end
    chk({tag, "_issue_cyc"}, vin_cyc, acc_c + N + 2);
  endtask

  task automatic chk_done(input string tag, input logic [OUT_DIM*DW-1:0] ey);
    chk({tag, "_done"}, n_done - done_b, 1);
    chk({tag, "_noerr"}, n_errp - err_b, 0);
    chk({tag, "_issues"}, n_vin - vin_b, 1);
    chk({tag, "_y"}, y_vec, ey);
    chk({tag, "_done_lat"}, done_cyc, vout_cyc + 1);
    chk({tag, "_idle"}, busy, 1'b0);
    chk({tag, "_wv"}, weights_valid, 1'b1);
  endtask

  localparam logic [IN_DIM*DW-1:0]  X_FIX  = {16'd1024, 16'd768, 16'd512, 16'd256};
  localparam logic [OUT_DIM*DW-1:0] Y_FIX  = {16'd1024, 16'd768, 16'd512, 16'd256};
  localparam logic [OUT_DIM*DW-1:0] Y_BIAS = {16'd1152, 16'd896, 16'd640, 16'd384};

  initial begin
    logic [IN_DIM*DW-1:0] xr;
    logic [OUT_DIM*DW-1:0] yk;
    int vk, dk;
    bit rl;
    rst_n = 1'b0; start = 1'b0; reload = 1'b0; x_vec = '0;
    inj_vld = 1'b0; inj_y = '0; lay_respond = 1'b1; lay_lat = 2;
    for (int m = 0; m < N; m++) rom[m] = (m < NW && (m / IN_DIM) == (m % IN_DIM)) ? 16'd256 : 16'd0;
    repeat (3) step();

    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_wv", weights_valid, 1'b0);
    chk("rst_lw", load_weight, 1'b0);
    chk("rst_lb", load_bias, 1'b0);
    chk("rst_vin", ll_valid_in, 1'b0);
    chk("rst_y", y_vec, '0);
    chk("rst_addr", pmem_addr, '0);
    rst_n = 1'b1;
    step();

    // Cold start: full load then identity result
    txn(1'b0, X_FIX);
    wait_end("t1");
    chk_load("t1");
    chk_done("t1", Y_FIX);

    // Restart in the very cycle done is visible; parameters already resident
    txn(1'b0, X_FIX);
    wait_end("t2");
    chk("t2_noload", slog.size() - log_b, 0);
    chk("t2_issue_cyc", vin_cyc, acc_c + 1);
    chk_done("t2", Y_FIX);

    // Biases changed, forced reload
    for (int i = 0; i < OUT_DIM; i++) rom[NW+i] = 16'd128;
    step();
    txn(1'b1, X_FIX);
    wait_end("t3");
    chk_load("t3");
    chk_done("t3", Y_BIAS);

    // Silent layer: timeout after TIMEOUT full waiting cycles
    lay_respond = 1'b0;
    txn(1'b0, X_FIX);
    wait_end("t4");
    chk("t4_issue_cyc", vin_cyc, acc_c + 1);
    chk("t4_err", n_errp - err_b, 1);
    chk("t4_err_cyc", err_cyc, vin_cyc + TIMEOUT + 1);
    chk("t4_nodone", n_done - done_b, 0);
    chk("t4_wv", weights_valid, 1'b0);
    chk("t4_y_held", y_vec, Y_BIAS);
    chk("t4_idle", busy, 1'b0);
    lay_respond = 1'b1;
    step();
    txn(1'b0, X_FIX);
    wait_end("t4r");
    chk_load("t4r");
    chk_done("t4r", Y_BIAS);

    // Reset in the middle of a load, on the 7th weight strobe
    step();
    txn(1'b1, X_FIX);
    repeat (7) step();
    chk("t5_lw7", load_weight, 1'b1);
    chk("t5_row7", w_row, 2'd1);
    chk("t5_col7", w_col, 2'd2);
    rst_n = 1'b0;
    step();
    chk("t5_lw", load_weight, 1'b0);
    chk("t5_lb", load_bias, 1'b0);
    chk("t5_vin", ll_valid_in, 1'b0);
    chk("t5_wv", weights_valid, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_y", y_vec, '0);
    rst_n = 1'b1;
    rand_rom();
    step();
    xr = rand_x();
    txn(1'b0, xr);
    wait_end("t5");
    chk_load("t5");
    chk_done("t5", ref_y(xr));

    // start during WAIT and ll_valid_out during IDLE are both ignored
    lay_lat = 12;
    step();
    xr = rand_x();
    txn(1'b0, xr);
    repeat (3) step();
    start = 1'b1; reload = 1'b1; x_vec = rand_x();
    step();
    start = 1'b0; reload = 1'b0;
    wait_end("t6");
    chk("t6_noload", slog.size() - log_b, 0);
    chk_done("t6", ref_y(xr));
    yk = y_vec;
    vk = n_vin;
    dk = n_done;
    step();
    inj_vld = 1'b1;
    inj_y = {rand_x()};
    step();
    inj_vld = 1'b0;
    repeat (3) step();
    chk("t6_idle_nodone", n_done - dk, 0);
    chk("t6_idle_noissue", n_vin - vk, 0);
    chk("t6_idle_y", y_vec, yk);
    chk("t6_idle_busy", busy, 1'b0);

    // Randomized runs, alternating reload with fresh ROM contents
    for (int r = 0; r < 6; r++) begin
      rl = (r % 2 == 0);
      if (rl) rand_rom();
      lay_lat = $urandom_range(1, 8);
      step();
      xr = rand_x();
      txn(rl, xr);
      wait_end($sformatf("r%0d", r));
      if (rl) begin
        chk_load($sformatf("r%0d", r));
      end else begin
        chk($sformatf("r%0d_noload", r), slog.size() - log_b, 0);
        chk($sformatf("r%0d_issue_cyc", r), vin_cyc, acc_c + 1);
      end
      chk_done($sformatf("r%0d", r), ref_y(xr));
    end

    step();
    chk("never_two_strobes", viol_two, 1'b0);
    chk("never_done_and_error", viol_both, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
